// File: rtl/arc_pkg.sv
// Shared types and constants for the ARC MIPS fetch stage.
//   fetch_state_t : fetch FSM encoding (IDLE, FETCH, HOLD, DRAIN)
//   fetch_entry_t : {instr, pcplus4} payload carried by the skid buffer
//   INSTR_NOP     : bubble written into IF/ID on reset and flush
//   ARC_RESET_PC  : default first fetch address
package arc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0000;
    localparam logic [XLEN-1:0] ARC_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcplus4;
    } fetch_entry_t;

    // Sequential PC step; wraps silently at the top of the address space.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return XLEN'(pc + XLEN'(4));
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pcplus4} skid buffer for the fetch stage.
// Catches a response that lands while decode is stalled.
//   clock, reset_n        : clock, async active-low reset
//   push_i / pop_i        : write entry / release entry
//   clear_i               : drop contents (redirect); wins over push and pop
//   instr_i, pcplus4_i    : entry written on push
//   full_o                : entry valid
//   instr_o, pcplus4_o    : stored entry (registered)
module fetch_skid_buf
    import arc_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pcplus4_i,
    output logic            full_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pcplus4_o
);

    fetch_entry_t entry_q, entry_d;
    logic         full_q, full_d;

    // Next-state: clear > push > pop.
    always_comb begin
        entry_d = entry_q;
        full_d  = full_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            entry_d.instr   = instr_i;
            entry_d.pcplus4 = pcplus4_i;
            full_d          = 1'b1;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_q.instr   <= INSTR_NOP;
            entry_q.pcplus4 <= '0;
            full_q          <= 1'b0;
        end else begin
            entry_q <= entry_d;
            full_q  <= full_d;
        end
    end

    assign full_o    = full_q;
    assign instr_o   = entry_q.instr;
    assign pcplus4_o = entry_q.pcplus4;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage of the ARC MIPS pipeline.
// Owns the PC, issues one-outstanding word fetches, and fills the IF/ID
// register with {instruction, PC+4}. Decode stall is absorbed by a one-entry
// skid buffer; branch/jump redirect flushes younger work.
// Build option: define ARC_BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics
// (the instruction right after the branch survives the redirect).
//   clock, reset_n                    : clock, async active-low reset
//   o_imem_req, o_imem_addr           : fetch request / word address (registered)
//   i_imem_rvalid, i_imem_rdata       : response, may come in the request cycle
//   i_con_stallD                      : decode stall, hold IF/ID
//   i_con_redirect, i_data_redirect_pc: taken branch/jump and its target
//   o_instrD, o_data_pcplus4D, o_validD : IF/ID register
module instr_fetch
    import arc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = ARC_RESET_PC
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_con_stallD,
    input  logic            i_con_redirect,
    input  logic [XLEN-1:0] i_data_redirect_pc,
    output logic [XLEN-1:0] o_instrD,
    output logic [XLEN-1:0] o_data_pcplus4D,
    output logic            o_validD
);

`ifdef ARC_BRANCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT_EN = 1'b1;
`else
    localparam bit DELAY_SLOT_EN = 1'b0;
`endif

    fetch_state_t    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    // DRAIN is waiting for the delay-slot response rather than a dead one.
    logic            keep_q, keep_d;

    logic            skid_push, skid_pop, skid_clear, skid_full;
    logic [XLEN-1:0] skid_instr, skid_pcp4;

    logic [XLEN-1:0] addr_plus4;
    logic            outstanding;
    logic            rsp_live;

    assign addr_plus4  = pc_plus4(addr_q);
    // A request is in flight whenever req is up (FETCH or DRAIN).
    assign outstanding = (state_q == FETCH) || (state_q == DRAIN);
    // Response belongs to the sequential stream (not a killed request).
    assign rsp_live    = i_imem_rvalid &&
                         ((state_q == FETCH) || ((state_q == DRAIN) && keep_q));

    fetch_skid_buf u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push_i    (skid_push),
        .pop_i     (skid_pop),
        .clear_i   (skid_clear),
        .instr_i   (i_imem_rdata),
        .pcplus4_i (addr_plus4),
        .full_o    (skid_full),
        .instr_o   (skid_instr),
        .pcplus4_o (skid_pcp4)
    );

    // Next-state and IF/ID update; redirect block at the end overrides the case.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        pcp4_d     = pcp4_q;
        valid_d    = valid_q;
        redir_pc_d = redir_pc_q;
        keep_d     = keep_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        skid_clear = 1'b0;

        case (state_q)
            IDLE: begin
                req_d   = 1'b1;
                state_d = FETCH;
            end

            FETCH: begin
                if (i_imem_rvalid) begin
                    addr_d = addr_plus4;
                    if (!i_con_stallD) begin
                        instr_d = i_imem_rdata;
                        pcp4_d  = addr_plus4;
                        valid_d = 1'b1;
                    end else begin
                        skid_push = 1'b1;
                        req_d     = 1'b0;
                        state_d   = HOLD;
                    end
                end else if (!i_con_stallD) begin
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (!i_con_stallD) begin
                    instr_d  = skid_instr;
                    pcp4_d   = skid_pcp4;
                    valid_d  = 1'b1;
                    skid_pop = 1'b1;
                    req_d    = 1'b1;
                    state_d  = FETCH;
                end
            end

            DRAIN: begin
                if (i_imem_rvalid) begin
                    addr_d = redir_pc_q;
                    keep_d = 1'b0;
                    if (keep_q && i_con_stallD) begin
                        // Delay slot arrives under stall: park it, target fetch follows HOLD.
                        skid_push = 1'b1;
                        req_d     = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        state_d = FETCH;
                        if (keep_q) begin
                            instr_d = i_imem_rdata;
                            pcp4_d  = addr_plus4;
                            valid_d = 1'b1;
                        end else if (!i_con_stallD) begin
                            valid_d = 1'b0;
                        end
                    end
                end else if (!i_con_stallD) begin
                    valid_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase

        // Redirect beats stall. Nothing can sit in decode while still in IDLE.
        if (i_con_redirect && (state_q != IDLE)) begin
            valid_d    = 1'b0;
            instr_d    = INSTR_NOP;
            skid_push  = 1'b0;
            skid_pop   = 1'b0;
            skid_clear = 1'b1;
            redir_pc_d = i_data_redirect_pc;
            keep_d     = 1'b0;
            req_d      = 1'b1;
            if (outstanding && !i_imem_rvalid) begin
                // Keep the bus stable until the in-flight response returns.
                state_d = DRAIN;
                addr_d  = addr_q;
                keep_d  = DELAY_SLOT_EN;
            end else begin
                state_d = FETCH;
                addr_d  = i_data_redirect_pc;
            end
            if (DELAY_SLOT_EN) begin
                if (skid_full) begin
                    instr_d = skid_instr;
                    pcp4_d  = skid_pcp4;
                    valid_d = 1'b1;
                end else if (rsp_live) begin
                    instr_d = i_imem_rdata;
                    pcp4_d  = addr_plus4;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instr_q    <= INSTR_NOP;
            pcp4_q     <= '0;
            valid_q    <= 1'b0;
            redir_pc_q <= RESET_PC;
            keep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            pcp4_q     <= pcp4_d;
            valid_q    <= valid_d;
            redir_pc_q <= redir_pc_d;
            keep_q     <= keep_d;
        end
    end

    assign o_imem_req      = req_q;
    assign o_imem_addr     = addr_q;
    assign o_instrD        = instr_q;
    assign o_data_pcplus4D = pcp4_q;
    assign o_validD        = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run scored against a program-order model of the instruction stream.
module tb_instr_fetch;

`ifdef ARC_BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] instr_d;
    logic [31:0] pcp4_d;
    logic        valid_d;

    always #5 clock = ~clock;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .o_imem_req         (req),
        .o_imem_addr        (addr),
        .i_imem_rvalid      (rvalid),
        .i_imem_rdata       (rdata),
        .i_con_stallD       (stall),
        .i_con_redirect     (redir),
        .i_data_redirect_pc (redir_pc),
        .o_instrD           (instr_d),
        .o_data_pcplus4D    (pcp4_d),
        .o_validD           (valid_d)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory: a request issued with latency L responds L cycles later (L=0 same cycle).
    int unsigned lat_cfg;
    logic        busy_q;
    int unsigned cnt_q;
    logic [31:0] maddr_q;

    always_comb begin
        if (busy_q) begin
            rvalid = (cnt_q == 0);
            rdata  = mem_word(maddr_q);
        end else begin
            rvalid = req && (lat_cfg == 0);
            rdata  = mem_word(addr);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= 0;
            maddr_q <= '0;
        end else if (busy_q) begin
            if (cnt_q == 0) busy_q <= 1'b0;
            else            cnt_q  <= cnt_q - 1;
        end else if (req && (lat_cfg != 0)) begin
            busy_q  <= 1'b1;
            cnt_q   <= lat_cfg - 1;
            maddr_q <= addr;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] exp_pc, ds_target, tgt;
    logic [31:0] prev_instr, prev_pcp4;
    logic        prev_valid, hold_pending, ds_pending;
    int          consumed, k;

    initial begin
        reset_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = '0; lat_cfg = 0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_req",   32'(req), 0);
        check_eq("rst_addr",  addr, 32'h0);
        check_eq("rst_instr", instr_d, 32'h0);
        check_eq("rst_pcp4",  pcp4_d, 32'h0);
        check_eq("rst_valid", 32'(valid_d), 0);
        reset_n = 1'b1;

        // Zero-wait streaming
        step();
        check_eq("s1_req", 32'(req), 1);
        check_eq("s1_addr", addr, 32'h0);
        check_eq("s1_valid", 32'(valid_d), 0);
        step();
        check_eq("s2_addr", addr, 32'h4);
        check_eq("s2_valid", 32'(valid_d), 1);
        check_eq("s2_pcp4", pcp4_d, 32'h4);
        check_eq("s2_instr", instr_d, mem_word(32'h0));
        step();
        check_eq("s3_addr", addr, 32'h8);
        check_eq("s3_pcp4", pcp4_d, 32'h8);

        // Stall for 3 cycles while the response for 8 arrives
        stall = 1'b1;
        step();
        check_eq("stall_req", 32'(req), 0);
        check_eq("stall_addr", addr, 32'hC);
        check_eq("stall_pcp4", pcp4_d, 32'h8);
        step();
        step();
        check_eq("stall_hold_pcp4", pcp4_d, 32'h8);
        check_eq("stall_hold_instr", instr_d, mem_word(32'h4));
        check_eq("stall_hold_valid", 32'(valid_d), 1);
        stall = 1'b0;
        step();
        check_eq("skid_req", 32'(req), 1);
        check_eq("skid_addr", addr, 32'hC);
        check_eq("skid_pcp4", pcp4_d, 32'hC);
        check_eq("skid_instr", instr_d, mem_word(32'h8));
        step();
        check_eq("after_skid_pcp4", pcp4_d, 32'h10);
        check_eq("after_skid_instr", instr_d, mem_word(32'hC));
        check_eq("after_skid_addr", addr, 32'h10);

        // Redirect while a 3-cycle fetch of 16 is outstanding
        lat_cfg = 3;
        step();
        check_eq("slow_addr", addr, 32'h10);
        check_eq("slow_req", 32'(req), 1);
        redir = 1'b1; redir_pc = 32'h400;
        step();
        redir = 1'b0; lat_cfg = 0;
        check_eq("drain_valid", 32'(valid_d), 0);
        check_eq("drain_addr", addr, 32'h10);
        check_eq("drain_req", 32'(req), 1);
        step();
        check_eq("drain_valid2", 32'(valid_d), 0);
        step();
        check_eq("tgt_addr", addr, 32'h400);
        check_eq("tgt_req", 32'(req), 1);
        check_eq("drop16_valid", 32'(valid_d), DS ? 32'd1 : 32'd0);
        check_eq("drop16_instr", instr_d, DS ? mem_word(32'h10) : 32'h0);
        step();
        check_eq("tgt_pcp4", pcp4_d, 32'h404);
        check_eq("tgt_instr", instr_d, mem_word(32'h400));
        check_eq("tgt_valid", 32'(valid_d), 1);

        // Redirect coincident with rvalid and stall
        stall = 1'b1; redir = 1'b1; redir_pc = 32'h800;
        step();
        stall = 1'b0; redir = 1'b0;
        check_eq("coin_addr", addr, 32'h800);
        check_eq("coin_valid", 32'(valid_d), DS ? 32'd1 : 32'd0);
        check_eq("coin_instr", instr_d, DS ? mem_word(32'h404) : 32'h0);
        step();
        check_eq("coin_next_pcp4", pcp4_d, 32'h804);
        check_eq("coin_next_valid", 32'(valid_d), 1);

        // Reset during HOLD
        stall = 1'b1;
        step();
        check_eq("hold_req", 32'(req), 0);
        #2;
        reset_n = 1'b0; stall = 1'b0;
        #1;
        check_eq("midrst_req", 32'(req), 0);
        check_eq("midrst_addr", addr, 32'h0);
        check_eq("midrst_valid", 32'(valid_d), 0);
        check_eq("midrst_instr", instr_d, 32'h0);
        check_eq("midrst_pcp4", pcp4_d, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step();
        check_eq("restart_req", 32'(req), 1);
        check_eq("restart_addr", addr, 32'h0);

        // Branch at 0x20 redirecting to 0x100
        k = 0;
        while (!(valid_d && (pcp4_d == 32'h24)) && (k < 40)) begin
            step();
            k++;
        end
        check_eq("br_reach_pcp4", pcp4_d, 32'h24);
        redir = 1'b1; redir_pc = 32'h100;
        step();
        redir = 1'b0;
        check_eq("br_addr", addr, 32'h100);
        check_eq("br_slot_valid", 32'(valid_d), DS ? 32'd1 : 32'd0);
        check_eq("br_slot_instr", instr_d, DS ? mem_word(32'h24) : 32'h0);
        step();
        check_eq("br_tgt_pcp4", pcp4_d, 32'h104);
        check_eq("br_tgt_instr", instr_d, mem_word(32'h100));

        // PC wrap at the top of the address space
        redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
        step();
        redir = 1'b0;
        k = 0;
        while (!(valid_d && (instr_d == mem_word(32'hFFFF_FFFC))) && (k < 10)) begin
            step();
            k++;
        end
        check_eq("wrap_instr", instr_d, mem_word(32'hFFFF_FFFC));
        check_eq("wrap_pcp4", pcp4_d, 32'h0);
        check_eq("wrap_addr", addr, 32'h0);

        // Randomized run against the program-order model
        reset_n = 1'b0; stall = 1'b0; redir = 1'b0; lat_cfg = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        exp_pc = 32'h0; ds_pending = 1'b0; hold_pending = 1'b0; consumed = 0;
        prev_instr = '0; prev_pcp4 = '0; prev_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (busy_q) begin
                check_eq("mem_req_held", 32'(req), 1);
                check_eq("mem_addr_stable", addr, maddr_q);
            end
            check_eq("addr_align", {30'b0, addr[1:0]}, 32'h0);
            if (hold_pending) begin
                check_eq("hold_valid", 32'(valid_d), 32'(prev_valid));
                check_eq("hold_instr", instr_d, prev_instr);
                check_eq("hold_pcp4", pcp4_d, prev_pcp4);
            end
            lat_cfg = $urandom_range(0, 3);
            stall   = ($urandom_range(0, 3) == 0);
            redir   = 1'b0;
            if (valid_d && !stall) begin
                check_eq("sb_instr", instr_d, mem_word(exp_pc));
                check_eq("sb_pcp4", pcp4_d, 32'(exp_pc + 32'd4));
                consumed++;
                if (ds_pending) begin
                    exp_pc     = ds_target;
                    ds_pending = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0
                        : (32'h1000 + ($urandom_range(0, 255) << 2));
                    redir    = 1'b1;
                    redir_pc = tgt;
                    if (DS) begin
                        exp_pc     = 32'(exp_pc + 32'd4);
                        ds_target  = tgt;
                        ds_pending = 1'b1;
                    end else begin
                        exp_pc = tgt;
                    end
                end else begin
                    exp_pc = 32'(exp_pc + 32'd4);
                end
            end
            hold_pending = stall && !redir;
            prev_instr   = instr_d;
            prev_pcp4    = pcp4_d;
            prev_valid   = valid_d;
        end
        check_eq("sb_progress", 32'(consumed >= 300), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
